cache_fill_ctrl: RTL and testbench

// - Miss handler for the I- and D-cache data arrays (128 blocks x 8 words x 16b, one-hot block/word enables).
// - Arbitrates misses from both caches onto the single shared multi-cycle memory.
// - Fills the granted cache's data array one word per returning beat.
// - Pulses that cache's tag write and done once the full block has been written.

---
 rtl/cache_fill_ctrl_pkg.sv | 29 ++
 rtl/cache_fill_ctrl_if.sv | 42 ++++
 rtl/cache_fill_ctrl_onehot_dec.sv | 17 +
 rtl/cache_fill_ctrl.sv | 136 +++++++++++++
 tb/tb_cache_fill_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_fill_ctrl_pkg.sv
// Shared definitions for the cache fill controller.
// Holds the geometry of the I/D data arrays, the FSM state encoding,
// the side-select encoding and the block-base address helper.
package cache_fill_ctrl_pkg;

    localparam int WORDS  = 8;              // words per block == fill beats
    localparam int NBLK   = 128;            // blocks per data array
    localparam int OFF_W  = 4;              // byte offset bits inside a block
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int BLK_W  = $clog2(NBLK);
    localparam int WORD_W = $clog2(WORDS);
    localparam int CNT_W  = 4;              // issue/receive counters, saturate at WORDS

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Block-aligned byte address: drop the in-block offset.
    function automatic logic [ADDR_W-1:0] blk_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Bus bundle between the fill controller, the two caches, the shared
// memory and the data/tag arrays.
//   I/D miss side : *_miss, *_addr, *_blk in;  *_done out
//   memory side   : mem_en, mem_addr out;       mem_data, mem_valid in
//   array side    : arr_sel, arr_we, arr_data, arr_blk_en, arr_word_en, tag_we out
//   status        : busy out
// master = the controller, slave = everything around it.
interface cache_fill_ctrl_if;

    logic                                      i_miss;
    logic [cache_fill_ctrl_pkg::ADDR_W-1:0]    i_addr;
    logic [cache_fill_ctrl_pkg::BLK_W-1:0]     i_blk;
    logic                                      i_done;
    logic                                      d_miss;
    logic [cache_fill_ctrl_pkg::ADDR_W-1:0]    d_addr;
    logic [cache_fill_ctrl_pkg::BLK_W-1:0]     d_blk;
    logic                                      d_done;
    logic                                      mem_en;
    logic [cache_fill_ctrl_pkg::ADDR_W-1:0]    mem_addr;
    logic [cache_fill_ctrl_pkg::DATA_W-1:0]    mem_data;
    logic                                      mem_valid;
    logic                                      arr_sel;
    logic                                      arr_we;
    logic [cache_fill_ctrl_pkg::DATA_W-1:0]    arr_data;
    logic [cache_fill_ctrl_pkg::NBLK-1:0]      arr_blk_en;
    logic [cache_fill_ctrl_pkg::WORDS-1:0]     arr_word_en;
    logic                                      tag_we;
    logic                                      busy;

    modport master (
        input  i_miss, i_addr, i_blk, d_miss, d_addr, d_blk, mem_data, mem_valid,
        output i_done, d_done, mem_en, mem_addr, arr_sel, arr_we, arr_data,
               arr_blk_en, arr_word_en, tag_we, busy
    );

    modport slave (
        output i_miss, i_addr, i_blk, d_miss, d_addr, d_blk, mem_data, mem_valid,
        input  i_done, d_done, mem_en, mem_addr, arr_sel, arr_we, arr_data,
               arr_blk_en, arr_word_en, tag_we, busy
    );

endinterface

// File: rtl/cache_fill_ctrl_onehot_dec.sv
// Binary index to one-hot decoder.
//   idx_i : IW-bit index
//   oh_o  : N-bit one-hot, bit idx_i set
module onehot_dec #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [IW-1:0] idx_i,
    output logic [N-1:0]  oh_o
);

    always_comb begin
        oh_o        = '0;
        oh_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss handler for the I- and D-cache data arrays.
// Arbitrates I/D misses (round-robin on a tie) onto the shared memory,
// issues one word read per cycle for the granted block, writes each
// returning beat into the granted array, then pulses tag_we and the
// matching done for one cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cache_fill_ctrl_if.master (miss, memory, array signals)
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    cache_fill_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);

    state_e             state_q;
    logic               sel_q;
    logic               last_q;        // side served most recently
    logic [ADDR_W-1:0]  base_q;
    logic [BLK_W-1:0]   blk_q;
    logic [CNT_W-1:0]   issue_cnt_q;
    logic [CNT_W-1:0]   recv_cnt_q;
    logic               mem_en_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic               tag_we_q;
    logic               i_done_q;
    logic               d_done_q;
    logic               busy_q;

    // Arbitration: a lone request wins; on a tie the side not served last wins.
    logic               req_any;
    logic               gnt_sel;
    logic [ADDR_W-1:0]  gnt_base;
    logic [BLK_W-1:0]   gnt_blk;

    always_comb begin
        req_any  = bus.i_miss | bus.d_miss;
        gnt_sel  = (bus.i_miss && bus.d_miss) ? ~last_q : bus.d_miss;
        gnt_base = gnt_sel ? blk_base(bus.d_addr) : blk_base(bus.i_addr);
        gnt_blk  = gnt_sel ? bus.d_blk : bus.i_blk;
    end

    logic [CNT_W-1:0] issue_nxt;
    assign issue_nxt = issue_cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_I;
            last_q      <= SEL_I;
            base_q      <= '0;
            blk_q       <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            tag_we_q    <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_any) begin
                        state_q     <= ST_FILL;
                        sel_q       <= gnt_sel;
                        base_q      <= gnt_base;
                        blk_q       <= gnt_blk;
                        issue_cnt_q <= '0;
                        recv_cnt_q  <= '0;
                        // First word is issued in the first FILL cycle.
                        mem_en_q    <= 1'b1;
                        mem_addr_q  <= gnt_base;
                        busy_q      <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (mem_en_q && issue_cnt_q != CNT_FULL) begin
                        issue_cnt_q <= issue_nxt;
                        if (issue_nxt < CNT_FULL) begin
                            mem_addr_q <= base_q + ADDR_W'({issue_nxt, 1'b0});
                        end else begin
                            mem_en_q   <= 1'b0;
                            mem_addr_q <= '0;
                        end
                    end
                    if (bus.mem_valid && recv_cnt_q != CNT_FULL) begin
                        recv_cnt_q <= recv_cnt_q + CNT_W'(1);
                        if (recv_cnt_q == CNT_LAST) begin
                            state_q  <= ST_DONE;
                            tag_we_q <= 1'b1;
                            i_done_q <= ~sel_q;
                            d_done_q <= sel_q;
                        end
                    end
                end
                ST_DONE: begin
                    state_q  <= ST_IDLE;
                    tag_we_q <= 1'b0;
                    i_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                    busy_q   <= 1'b0;
                    last_q   <= sel_q;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Array write path follows the returning beat combinationally so the
    // word lands in the same cycle memory presents it.
    logic              beat;
    logic [NBLK-1:0]   blk_oh;
    logic [WORDS-1:0]  word_oh;

    assign beat = (state_q == ST_FILL) && bus.mem_valid;

    onehot_dec #(.N(NBLK))  u_blk_dec  (.idx_i(blk_q),                      .oh_o(blk_oh));
    onehot_dec #(.N(WORDS)) u_word_dec (.idx_i(recv_cnt_q[WORD_W-1:0]),     .oh_o(word_oh));

    assign bus.arr_we      = beat;
    assign bus.arr_data    = beat ? bus.mem_data : '0;
    assign bus.arr_word_en = beat ? word_oh : '0;
    assign bus.arr_blk_en  = (beat || state_q == ST_DONE) ? blk_oh : '0;
    assign bus.arr_sel     = sel_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.tag_we      = tag_we_q;
    assign bus.i_done      = i_done_q;
    assign bus.d_done      = d_done_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: directed misses push expected memory
// issues, array writes and done events; a monitor pops and compares them
// whenever the DUT presents mem_en, arr_we or tag_we.
module tb_cache_fill_ctrl;
    import cache_fill_ctrl_pkg::*;

    localparam int MEM_LAT = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    cache_fill_ctrl_if bus();

    cache_fill_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [15:0] addr; int cyc;} mem_exp_t;
    typedef struct {logic sel; logic [6:0] blk; int word; logic [15:0] data;} wr_exp_t;
    typedef struct {logic sel; logic [6:0] blk; int cyc;} done_exp_t;

    mem_exp_t  exp_mem[$];
    wr_exp_t   exp_wr[$];
    done_exp_t exp_done[$];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: DUT event with nothing expected (cycle %0d)", name, cyc);
    endtask

    function automatic logic [191:0] outs();
        return 192'({bus.busy, bus.tag_we, bus.arr_word_en, bus.arr_blk_en, bus.arr_data,
                     bus.arr_we, bus.arr_sel, bus.mem_addr, bus.mem_en, bus.d_done, bus.i_done});
    endfunction

    // Memory model: fixed latency, in-order, data = address, optional one-cycle bubble.
    logic [15:0] mq_a[$];
    int          mq_t[$];
    int          ret_total = 0;
    int          gap_at = -1;
    bit          gap_used = 1'b0;

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_en) begin
                mq_a.push_back(bus.mem_addr);
                mq_t.push_back(cyc + MEM_LAT);
            end
            bus.mem_valid = 1'b0;
            bus.mem_data  = '0;
            if (mq_t.size() != 0 && mq_t[0] <= cyc) begin
                if (ret_total == gap_at && !gap_used) begin
                    gap_used = 1'b1;
                end else begin
                    bus.mem_valid = 1'b1;
                    bus.mem_data  = mq_a.pop_front();
                    void'(mq_t.pop_front());
                    ret_total++;
                end
            end
        end
    end

    // Monitor
    logic [127:0] one128 = 128'd1;

    task automatic monitor_step();
        mem_exp_t   me;
        wr_exp_t    we;
        done_exp_t  de;
        logic [7:0] wexp;
        if (bus.mem_en) begin
            if (exp_mem.size() == 0) unexpected("mem_issue");
            else begin
                me = exp_mem.pop_front();
                chk("mem_addr", 192'(bus.mem_addr), 192'(me.addr));
                chk("mem_cycle", 192'(cyc), 192'(me.cyc));
            end
        end
        if (bus.arr_we) begin
            if (exp_wr.size() == 0) unexpected("arr_write");
            else begin
                we   = exp_wr.pop_front();
                wexp = 8'(1 << we.word);
                chk("wr_sel", 192'(bus.arr_sel), 192'(we.sel));
                chk("wr_blk_en", 192'(bus.arr_blk_en), 192'(one128 << we.blk));
                chk("wr_word_en", 192'(bus.arr_word_en), 192'(wexp));
                chk("wr_data", 192'(bus.arr_data), 192'(we.data));
                chk("wr_busy", 192'(bus.busy), 192'(1));
            end
        end else if (!bus.tag_we) begin
            chk("quiet", 192'({bus.arr_blk_en, bus.arr_word_en, bus.arr_data, bus.i_done, bus.d_done}), '0);
        end
        if (bus.tag_we) begin
            if (exp_done.size() == 0) unexpected("tag_we");
            else begin
                de = exp_done.pop_front();
                chk("done_cycle", 192'(cyc), 192'(de.cyc));
                chk("done_sel", 192'(bus.arr_sel), 192'(de.sel));
                chk("done_blk_en", 192'(bus.arr_blk_en), 192'(one128 << de.blk));
                chk("done_pulse", 192'({bus.i_done, bus.d_done}), 192'({~de.sel, de.sel}));
                chk("done_no_write", 192'({bus.arr_we, bus.arr_word_en, bus.busy}), 192'({1'b0, 8'h00, 1'b1}));
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n === 1'b1) monitor_step();
    end

    // Stimulus helpers
    task automatic tick();
        @(negedge clk);
        // Requesters see their tag hit once done pulses and drop the miss.
        if (bus.i_done) bus.i_miss = 1'b0;
        if (bus.d_done) bus.d_miss = 1'b0;
    endtask

    task automatic raise(input logic sel, input logic [15:0] addr, input logic [6:0] blk);
        if (sel) begin
            bus.d_miss = 1'b1; bus.d_addr = addr; bus.d_blk = blk;
        end else begin
            bus.i_miss = 1'b1; bus.i_addr = addr; bus.i_blk = blk;
        end
    endtask

    // Expected fill granted in cycle g; extra = memory bubbles in the block.
    task automatic expect_fill(input logic sel, input logic [15:0] addr, input logic [6:0] blk,
                               input int g, input int extra);
        logic [15:0] base;
        mem_exp_t    me;
        wr_exp_t     we;
        done_exp_t   de;
        base = {addr[15:4], 4'h0};
        for (int w = 0; w < 8; w++) begin
            me.addr = base + 16'(2 * w); me.cyc = g + 1 + w;
            exp_mem.push_back(me);
            we.sel = sel; we.blk = blk; we.word = w; we.data = base + 16'(2 * w);
            exp_wr.push_back(we);
        end
        de.sel = sel; de.blk = blk; de.cyc = g + 13 + extra;
        exp_done.push_back(de);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (exp_done.size() == 0 && !bus.i_miss && !bus.d_miss && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_complete"}, 192'(ok), 192'(1));
    endtask

    initial begin
        int       g;
        mem_exp_t me;
        wr_exp_t  we;
        rst_n = 1'b0;
        bus.i_miss = 1'b0; bus.i_addr = '0; bus.i_blk = '0;
        bus.d_miss = 1'b0; bus.d_addr = '0; bus.d_blk = '0;
        tick(); tick();
        #2 chk("reset_outputs", outs(), '0);
        tick();
        rst_n = 1'b1;
        tick();
        #2 chk("idle_outputs", outs(), '0);

        // Single I miss
        tick(); g = cyc;
        raise(SEL_I, 16'h1236, 7'd5);
        expect_fill(SEL_I, 16'h1236, 7'd5, g, 0);
        wait_idle("single_i", 40);

        // Tie: D wins first (I served last), then I
        tick(); g = cyc;
        raise(SEL_D, 16'h2000, 7'd10);
        raise(SEL_I, 16'h3008, 7'd11);
        expect_fill(SEL_D, 16'h2000, 7'd10, g, 0);
        expect_fill(SEL_I, 16'h3008, 7'd11, g + 14, 0);
        wait_idle("tie1", 60);

        // D arrives mid I fill: waits for I's DONE
        tick(); g = cyc;
        raise(SEL_I, 16'h4444, 7'd20);
        expect_fill(SEL_I, 16'h4444, 7'd20, g, 0);
        expect_fill(SEL_D, 16'h5550, 7'd21, g + 14, 0);
        repeat (5) tick();
        raise(SEL_D, 16'h5550, 7'd21);
        wait_idle("midfill", 60);

        // Repeated tie after D served last: I first
        tick(); g = cyc;
        raise(SEL_I, 16'h6660, 7'd30);
        raise(SEL_D, 16'h7770, 7'd31);
        expect_fill(SEL_I, 16'h6660, 7'd30, g, 0);
        expect_fill(SEL_D, 16'h7770, 7'd31, g + 14, 0);
        wait_idle("tie2", 60);

        // Reset after three beats aborts the fill
        tick(); g = cyc;
        raise(SEL_I, 16'h8880, 7'd40);
        for (int w = 0; w < 7; w++) begin
            me.addr = 16'h8880 + 16'(2 * w); me.cyc = g + 1 + w;
            exp_mem.push_back(me);
        end
        for (int w = 0; w < 3; w++) begin
            we.sel = SEL_I; we.blk = 7'd40; we.word = w; we.data = 16'h8880 + 16'(2 * w);
            exp_wr.push_back(we);
        end
        repeat (8) tick();
        rst_n = 1'b0;
        bus.i_miss = 1'b0;
        #2 chk("abort_outputs", outs(), '0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("abort_drained", 192'({exp_mem.size(), exp_wr.size(), exp_done.size()}), '0);
        tick(); g = cyc;
        raise(SEL_I, 16'h8880, 7'd40);
        expect_fill(SEL_I, 16'h8880, 7'd40, g, 0);
        wait_idle("refill", 40);

        // One-cycle memory bubble after the third beat
        gap_at = ret_total + 3;
        tick(); g = cyc;
        raise(SEL_I, 16'h9A4C, 7'd33);
        expect_fill(SEL_I, 16'h9A4C, 7'd33, g, 1);
        wait_idle("gap", 40);

        // Top of address space, last block
        tick(); g = cyc;
        raise(SEL_D, 16'hFFF0, 7'd127);
        expect_fill(SEL_D, 16'hFFF0, 7'd127, g, 0);
        wait_idle("boundary", 40);

        repeat (3) tick();
        chk("queues_empty", 192'({exp_mem.size(), exp_wr.size(), exp_done.size()}), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
